// File: rtl/ibex_qed_wb_checker.sv
// SQED writeback checker: shadows the RF from committed writes, counts QED-valid writes per half,
// and on request waits for balanced counts then sweeps x{i} vs x{i+16}. Macro IBEX_QED_CHECKER_CAPTURE_EN latches first mismatch.
module ibex_qed_wb_checker #(
  parameter int CntWidth      = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rf_we_wb_i,
  input  logic [4:0]          rf_waddr_wb_i,
  input  logic [31:0]         rf_wdata_wb_i,
  input  logic                qed_vld_i,
  input  logic                check_req_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic                error_o,
  output logic [CntWidth-1:0] orig_cnt_o,
  output logic [CntWidth-1:0] dup_cnt_o,
  output logic [3:0]          err_idx_o,
  output logic [31:0]         err_orig_o,
  output logic [31:0]         err_dup_o
);

  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_MATCH, SWEEP, REPORT} state_e;

  state_e              state, state_nxt;
  logic [31:0]         shadow [32];
  logic [CntWidth-1:0] orig_cnt, dup_cnt;
  logic [TW-1:0]       tcnt;
  logic [3:0]          idx;
  logic                mismatch_seen, timed_out, error_q;
  logic                wr_en, cnt_en, pair_mismatch;
  logic [31:0]         orig_val, dup_val;

  assign wr_en  = rf_we_wb_i && (rf_waddr_wb_i != 5'd0);
  assign cnt_en = wr_en && qed_vld_i;

  // x0 is never written, but the pair compare still forces it to 0 explicitly
  assign orig_val      = (idx == 4'd0) ? 32'd0 : shadow[{1'b0, idx}];
  assign dup_val       = shadow[{1'b1, idx}];
  assign pair_mismatch = (orig_val != dup_val);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[rf_waddr_wb_i] <= rf_wdata_wb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      orig_cnt <= '0;
      dup_cnt  <= '0;
    end else if (cnt_en) begin
      if (!rf_waddr_wb_i[4] && (orig_cnt != '1)) orig_cnt <= orig_cnt + 1'b1;
      if ( rf_waddr_wb_i[4] && (dup_cnt  != '1)) dup_cnt  <= dup_cnt  + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (check_req_i) state_nxt = WAIT_MATCH;
      WAIT_MATCH: begin
        // a write in flight may change the counts next cycle, so wait it out
        if ((orig_cnt == dup_cnt) && !rf_we_wb_i)       state_nxt = SWEEP;
        else if (tcnt == TW'(TimeoutCycles - 1))        state_nxt = REPORT;
      end
      SWEEP:      if (idx == 4'd15) state_nxt = REPORT;
      REPORT:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      tcnt          <= '0;
      idx           <= '0;
      mismatch_seen <= 1'b0;
      timed_out     <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (check_req_i) begin
          tcnt          <= '0;
          idx           <= '0;
          mismatch_seen <= 1'b0;
          timed_out     <= 1'b0;
        end
        WAIT_MATCH: begin
          tcnt <= tcnt + 1'b1;
          if (state_nxt == REPORT) timed_out <= 1'b1;
        end
        SWEEP: begin
          idx <= idx + 4'd1;
          if (pair_mismatch) mismatch_seen <= 1'b1;
        end
        REPORT:  if (!pass_o) error_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy_o     = (state != IDLE);
  assign done_o     = (state == REPORT);
  assign pass_o     = done_o && !mismatch_seen && !timed_out;
  assign timeout_o  = done_o && timed_out;
  assign error_o    = error_q;
  assign orig_cnt_o = orig_cnt;
  assign dup_cnt_o  = dup_cnt;

`ifdef IBEX_QED_CHECKER_CAPTURE_EN
  logic        cap_vld;
  logic [3:0]  cap_idx;
  logic [31:0] cap_orig, cap_dup;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_vld  <= 1'b0;
      cap_idx  <= '0;
      cap_orig <= '0;
      cap_dup  <= '0;
    end else if ((state == SWEEP) && pair_mismatch && !cap_vld) begin
      cap_vld  <= 1'b1;
      cap_idx  <= idx;
      cap_orig <= orig_val;
      cap_dup  <= dup_val;
    end
  end

  assign err_idx_o  = cap_idx;
  assign err_orig_o = cap_orig;
  assign err_dup_o  = cap_dup;
`else
  assign err_idx_o  = '0;
  assign err_orig_o = '0;
  assign err_dup_o  = '0;
`endif

endmodule

// File: tb/tb_ibex_qed_wb_checker.sv
// Directed bench for ibex_qed_wb_checker: a shadow/counter model plus a per-cycle compare process,
// with hand-computed latencies and capture values for each scenario.
module tb_ibex_qed_wb_checker;
  localparam int CW   = 4;
  localparam int TO   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic          we = 1'b0, qed = 1'b0, req = 1'b0;
  logic [4:0]    waddr = '0;
  logic [31:0]   wdata = '0;
  logic          busy, done, pass, tmo, err;
  logic [CW-1:0] ocnt, dcnt;
  logic [3:0]    eidx;
  logic [31:0]   eorig, edup;

  ibex_qed_wb_checker #(.CntWidth(CW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .rf_we_wb_i(we), .rf_waddr_wb_i(waddr), .rf_wdata_wb_i(wdata),
    .qed_vld_i(qed), .check_req_i(req), .busy_o(busy), .done_o(done), .pass_o(pass),
    .timeout_o(tmo), .error_o(err), .orig_cnt_o(ocnt), .dup_cnt_o(dcnt),
    .err_idx_o(eidx), .err_orig_o(eorig), .err_dup_o(edup)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: architectural shadow and saturating per-half counts
  logic [31:0] msh [32];
  int morig = 0, mdup = 0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) msh[i] <= 0;
      morig <= 0;
      mdup  <= 0;
    end else if (we && waddr != 0) begin
      msh[waddr] <= wdata;
      if (qed && !waddr[4]) morig <= (morig == CMAX) ? CMAX : morig + 1;
      if (qed &&  waddr[4]) mdup  <= (mdup  == CMAX) ? CMAX : mdup + 1;
    end
  end

  logic        exp_to = 1'b0;
  logic        merr = 1'b0, merr_pend = 1'b0, mcap_v = 1'b0;
  int          mcap_idx = 0;
  logic [31:0] mcap_o = 0, mcap_d = 0;
  int          done_cnt = 0, done_cyc = 0;
  logic        last_pass = 1'b0, last_to = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      merr = 0; merr_pend = 0; mcap_v = 0;
      mcap_idx = 0; mcap_o = 0; mcap_d = 0;
    end else begin
      logic        allm, ep;
      int          first;
      logic [31:0] a;
      merr = merr | merr_pend;
      merr_pend = 0;
      chk("orig_cnt", ocnt, morig);
      chk("dup_cnt", dcnt, mdup);
      chk("error_sticky", err, merr);
      if (done) begin
        allm = 1; first = 0;
        for (int i = 0; i < 16; i++) begin
          a = (i == 0) ? 32'd0 : msh[i];
          if (allm && a != msh[i+16]) begin allm = 0; first = i; end
        end
        ep = !exp_to && allm;
        chk("pass", pass, ep);
        chk("timeout", tmo, exp_to);
        if (!exp_to && !allm && !mcap_v) begin
          mcap_v = 1; mcap_idx = first;
          mcap_o = (first == 0) ? 32'd0 : msh[first];
          mcap_d = msh[first+16];
        end
`ifdef IBEX_QED_CHECKER_CAPTURE_EN
        chk("err_idx", eidx, mcap_idx);
        chk("err_orig", eorig, mcap_o);
        chk("err_dup", edup, mcap_d);
`else
        chk("err_idx_tied", eidx, 0);
        chk("err_orig_tied", eorig, 0);
        chk("err_dup_tied", edup, 0);
`endif
        if (!ep) merr_pend = 1;
        done_cnt++; done_cyc = cyc; last_pass = pass; last_to = tmo;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [4:0] ad, input logic [31:0] d, input logic q);
    we = 1; waddr = ad; wdata = d; qed = q;
    tick();
    we = 0; qed = 0;
  endtask

  task automatic request(output int c0);
    c0 = cyc;
    req = 1;
    tick();
    req = 0;
  endtask

  task automatic wait_done(input int c0, input int lat, input string nm);
    int n0 = done_cnt;
    int k = 0;
    while (done_cnt == n0 && k < 200) begin tick(); k++; end
    if (done_cnt == n0) chk({nm, "_done_seen"}, 0, 1);
    else begin
      chk({nm, "_latency"}, done_cyc - c0, lat);
      chk({nm, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    int c0, n0;
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_timeout", tmo, 0); chk("rst_error", err, 0);
    chk("rst_cnts", {ocnt, dcnt}, 0); chk("rst_capture", {eidx, eorig, edup}, 0);
    rst = 0;
    tick();

    // matched pair, best-case latency
    wr(5, 32'h1234, 1); wr(21, 32'h1234, 1);
    request(c0);
    chk("busy_after_req", busy, 1);
    wait_done(c0, 18, "match");
    chk("match_pass", last_pass, 1); chk("match_to", last_to, 0);
    chk("match_cnts", {ocnt, dcnt}, {4'd1, 4'd1}); chk("match_err", err, 0);

    // mismatch at pair 3
    wr(3, 32'hA, 1); wr(19, 32'hB, 1);
    request(c0);
    wait_done(c0, 18, "mism");
    chk("mism_pass", last_pass, 0); chk("mism_err", err, 1);
`ifdef IBEX_QED_CHECKER_CAPTURE_EN
    chk("mism_idx", eidx, 3); chk("mism_orig", eorig, 32'hA); chk("mism_dup", edup, 32'hB);
`endif

    // fix x19 without counting; writeback activity delays the sweep two cycles
    wr(19, 32'hA, 0);
    request(c0);
    we = 1; waddr = 0; wdata = 32'h99; qed = 1;
    tick(); tick();
    we = 0; qed = 0;
    wait_done(c0, 20, "wblock");
    chk("wblock_pass", last_pass, 1); chk("wblock_err_sticky", err, 1);
`ifdef IBEX_QED_CHECKER_CAPTURE_EN
    chk("wblock_cap_hold", eidx, 3);
`endif

    // unbalanced counts -> timeout
    wr(7, 32'h77, 1);
    exp_to = 1;
    request(c0);
    wait_done(c0, TO + 1, "tmo");
    chk("tmo_flag", last_to, 1); chk("tmo_pass", last_pass, 0);
    exp_to = 0;

    // late match: duplicate write lands 5 cycles after the request
    request(c0);
    repeat (4) tick();
    wr(23, 32'h77, 1);
    wait_done(c0, 23, "late");
    chk("late_pass", last_pass, 1);

    // reset while sweeping pair 8
    request(c0);
    repeat (9) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_busy", busy, 0); chk("rst_mid_cnts", {ocnt, dcnt}, 0);
    chk("rst_mid_done", done, 0); chk("rst_mid_err", err, 0);
    n0 = done_cnt;
    repeat (25) tick();
    chk("rst_mid_no_done", done_cnt - n0, 0);

    // qed-filtered x16 write and dropped x0 write
    wr(16, 32'hDEAD, 0); wr(0, 32'h55, 1);
    chk("filt_cnts", {ocnt, dcnt}, 0);
    request(c0);
    wait_done(c0, 18, "filt");
    chk("filt_pass", last_pass, 0);
`ifdef IBEX_QED_CHECKER_CAPTURE_EN
    chk("filt_idx", eidx, 0); chk("filt_orig", eorig, 0); chk("filt_dup", edup, 32'hDEAD);
`endif

    // counter saturation
    for (int i = 0; i < CMAX + 2; i++) wr(1, i, 1);
    chk("sat_orig", ocnt, CMAX); chk("sat_dup", dcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ibex_qed_wb_checker.md
# ibex_qed_wb_checker

Consumer of the writeback stage's register-file write port and `qed_vld_out_final_o` in the SQED verification build. Keeps a shadow copy of the architectural register file from committed writeback writes and counts QED-valid writes to the original half (x0–x15) and the duplicate half (x16–x31). On request, it waits until both halves have retired the same number of writes, then sweeps the 16 register pairs and reports pass/fail for the formal/simulation harness.

## Interface
Parameters:
- `CntWidth`, 16: width of the per-half write counters.
- `TimeoutCycles`, 1024: maximum cycles in `WAIT_MATCH` before reporting a timeout. Must be ≥1.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `rf_we_wb_i` in 1: writeback RF write enable.
- `rf_waddr_wb_i` in 5: writeback RF write address.
- `rf_wdata_wb_i` in 32: writeback RF write data.
- `qed_vld_i` in 1: QED-valid qualifier for the current writeback write, from `qed_vld_out_final_o`.
- `check_req_i` in 1: request a consistency check. Sampled only in `IDLE`.
- `busy_o` out 1: high in any state other than `IDLE`.
- `done_o` out 1: one-cycle pulse in `REPORT`.
- `pass_o` out 1: valid with `done_o`. High when all 16 pairs matched and there was no timeout.
- `timeout_o` out 1: valid with `done_o`. High when `WAIT_MATCH` expired.
- `error_o` out 1: sticky. Set on the first failing report; cleared only by reset.
- `orig_cnt_o` out `CntWidth`: count of QED-valid writes to x1–x15.
- `dup_cnt_o` out `CntWidth`: count of QED-valid writes to x16–x31.
- `err_idx_o` out 4: index i of the first mismatching pair (x{i} vs x{i+16}).
- `err_orig_o` out 32: value of x{i} at the first mismatch.
- `err_dup_o` out 32: value of x{i+16} at the first mismatch.

## Operation
- **Shadow RF:** 32×32 storage.
  - Written when `rf_we_wb_i` is high and `rf_waddr_wb_i != 0`, regardless of `qed_vld_i`.
  - Writes to x0 are dropped; shadow x0 always reads 0.
- **Counters:**
  - Increment only when `rf_we_wb_i` and `qed_vld_i` are both high and the address is nonzero.
  - `rf_waddr_wb_i[4]=0` increments `orig_cnt`; `rf_waddr_wb_i[4]=1` increments `dup_cnt`.
  - Counters saturate at all-ones. They are never cleared by a check.
- **FSM states:** `IDLE`, `WAIT_MATCH`, `SWEEP`, `REPORT`.
  - `IDLE` → `WAIT_MATCH` on `check_req_i`. Clears the timeout counter and the pair index.
  - `WAIT_MATCH` → `SWEEP` when registered `orig_cnt == dup_cnt` and `rf_we_wb_i` is low that cycle.
  - `WAIT_MATCH` → `REPORT` with timeout when the timeout counter reaches `TimeoutCycles-1`.
  - `SWEEP`: compare shadow[i] with shadow[i+16] for i=0..15, one pair per cycle. After i=15, go to `REPORT`.
  - `SWEEP` does not abort on a mismatch; it records it and continues.
  - `REPORT`: assert `done_o`, `pass_o`, `timeout_o` for one cycle, then return to `IDLE`.
- **Sweep compare values:** the sweep reads registered shadow contents. A same-cycle write to the pair being compared is not visible until the next cycle. Writes during `SWEEP` still update the shadow and counters.
- **Pair x0/x16:** compares constant 0 with shadow x16.
- **`error_o`:** set in `REPORT` when `pass_o` is 0.
- **Reset values:** shadow RF all 0, counters 0, state `IDLE`, and every output 0.
- **Reset mid-operation:** any state returns to `IDLE` on the next edge. No `done_o` is produced for the aborted check.

## Timing
- Write → shadow/counter visible: 1 cycle (registered).
- `check_req_i` → `busy_o` high: 1 cycle.
- Best-case request → `done_o`: 1 (`WAIT_MATCH`) + 16 (`SWEEP`) + 1 = `done_o` 18 cycles after the request edge.
- `check_req_i` is ignored while `busy_o` is high.
- A request in the `REPORT` cycle is ignored. A request in the first `IDLE` cycle after `REPORT` is accepted.
- Timeout path: `done_o` exactly `TimeoutCycles`+1 cycles after entering `WAIT_MATCH`, provided counts never match.

## Configuration
- Macro: `IBEX_QED_CHECKER_CAPTURE_EN`.
- **Defined:**
  - `err_idx_o`, `err_orig_o`, `err_dup_o` latch the first mismatch since reset.
  - The capture holds until reset, across later checks.
  - It is set on the same edge that the mismatch is sampled in `SWEEP`.
- **Undefined:**
  - Capture registers are not built and the three outputs are tied to 0.
  - `pass_o` and `error_o` behaviour is unchanged.

## Test plan
- **Matched pair:** write x5=0x1234 (qed=1), then x21=0x1234 (qed=1), then pulse `check_req_i` → `done_o` 18 cycles later with `pass_o`=1, `timeout_o`=0, counts 1/1.
- **Mismatch:** x3=0xA, x19=0xB, check → `pass_o`=0, `error_o`=1 sticky. With capture enabled: `err_idx_o`=3, `err_orig_o`=0xA, `err_dup_o`=0xB.
- **Unbalanced counts:** write only x7 with `TimeoutCycles`=8, then check → `done_o` with `timeout_o`=1, `pass_o`=0, 9 cycles after entering `WAIT_MATCH`.
- **Late match:** issue the check with counts 2/1, deliver the duplicate write 5 cycles later → sweep starts the cycle after counts match, then `pass_o`=1.
- **Filtering and x0:** write x16 with `qed_vld_i`=0 and a nonzero value, plus a write to x0 → counters unchanged, x0 write dropped. A check then fails at pair 0 with `err_dup_o` = the written value.
- **Reset during `SWEEP`:** assert `rst_i` at i=8 → next cycle: `IDLE`, counters 0, `busy_o` 0, and no `done_o` pulse.
